// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams a big-endian, length-prefixed
// instruction image from the UART into instruction memory. The CPU is held in
// reset until the whole image has been written.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, a trailing
// XOR checksum byte must match the payload before the CPU is released.
module program_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  xreset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_xreset,
   output logic                  loading,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      ST_LEN   = 3'd0,
      ST_DATA  = 3'd1,
      ST_DRAIN = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK = 3'd3,
`endif
      ST_RUN   = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   // Largest legal word count; 33 bits so ADDR_WIDTH up to 32 still fits.
   localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

   state_t                state_r;
   logic [1:0]            byte_cnt_r;
   logic [23:0]           asm_r;        // first three bytes of the word in flight
   logic [31:0]           len_r;
   logic [ADDR_WIDTH:0]   word_idx_r;
   logic                  imem_we_r;
   logic [ADDR_WIDTH-1:0] imem_addr_r;
   logic [31:0]           imem_wdata_r;
   logic                  cpu_xreset_r;
   logic                  loading_r;
   logic                  done_r;
   logic                  error_r;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum_r;
`endif

   logic [31:0] word_s;
   logic        byte_last_s;
   logic        len_too_big_s;
   logic [32:0] next_idx_s;
   logic        last_word_s;

   assign word_s        = {asm_r, rx_data};
   assign byte_last_s   = (byte_cnt_r == 2'd3);
   assign len_too_big_s = ({1'b0, word_s} > MAX_WORDS);
   assign next_idx_s    = 33'(word_idx_r) + 33'd1;
   assign last_word_s   = (next_idx_s == {1'b0, len_r});

   assign imem_we    = imem_we_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign cpu_xreset = cpu_xreset_r;
   assign loading    = loading_r;
   assign done       = done_r;
   assign error      = error_r;

   // Load sequencer: byte assembly, memory write strobes and CPU release.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         state_r      <= ST_LEN;
         byte_cnt_r   <= 2'd0;
         asm_r        <= 24'd0;
         len_r        <= 32'd0;
         word_idx_r   <= '0;
         imem_we_r    <= 1'b0;
         imem_addr_r  <= '0;
         imem_wdata_r <= 32'd0;
         cpu_xreset_r <= 1'b0;
         loading_r    <= 1'b1;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_r       <= 8'h00;
`endif
      end else begin
         imem_we_r <= 1'b0;
         case (state_r)
            ST_LEN: begin
               if (rx_valid) begin
                  asm_r      <= word_s[23:0];
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_last_s) begin
                     len_r      <= word_s;
                     word_idx_r <= '0;
`ifdef LOADER_CHECKSUM_EN
                     csum_r     <= 8'h00;
`endif
                     if (word_s == 32'd0) begin
                        state_r <= ST_DRAIN;
                     end else if (len_too_big_s) begin
                        state_r   <= ST_ERROR;
                        loading_r <= 1'b0;
                        error_r   <= 1'b1;
                     end else begin
                        state_r <= ST_DATA;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  asm_r      <= word_s[23:0];
                  byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum_r     <= csum_r ^ rx_data;
`endif
                  if (byte_last_s) begin
                     imem_we_r    <= 1'b1;
                     imem_addr_r  <= word_idx_r[ADDR_WIDTH-1:0];
                     imem_wdata_r <= word_s;
                     word_idx_r   <= next_idx_s[ADDR_WIDTH:0];
                     if (last_word_s) begin
                        state_r <= ST_DRAIN;
                     end
                  end
               end
            end
            ST_DRAIN: begin
`ifdef LOADER_CHECKSUM_EN
               state_r <= ST_CHECK;
`else
               state_r      <= ST_RUN;
               cpu_xreset_r <= 1'b1;
               loading_r    <= 1'b0;
               done_r       <= 1'b1;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (rx_valid) begin
                  loading_r <= 1'b0;
                  if (rx_data == csum_r) begin
                     state_r      <= ST_RUN;
                     cpu_xreset_r <= 1'b1;
                     done_r       <= 1'b1;
                  end else begin
                     state_r <= ST_ERROR;
                     error_r <= 1'b1;
                  end
               end
            end
`endif
            ST_RUN: begin
               state_r <= ST_RUN;
            end
            ST_ERROR: begin
               state_r <= ST_ERROR;
            end
            default: begin
               // Unreachable encoding: fail safe with the CPU held in reset.
               state_r      <= ST_ERROR;
               cpu_xreset_r <= 1'b0;
               loading_r    <= 1'b0;
               done_r       <= 1'b0;
               error_r      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time controller that sequences the MIPS core's instruction memory load from the serial port. Takes received bytes from the UART receiver and assembles them into 32-bit words. Writes the words to instruction memory at consecutive word addresses, holding the CPU in reset until the image is fully written. Sits in `test_top` between the UART receiver (`rs_rx` path), the instruction-memory write port and the CPU's reset input.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `xreset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte from the UART receiver.
- `rx_valid`  in  1  one-cycle pulse; `rx_data` is valid in this cycle. May be high on consecutive cycles.
- `imem_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `imem_addr`  out  ADDR_WIDTH  word address for the write.
- `imem_wdata`  out  32  write data.
- `cpu_xreset`  out  1  active-low reset to the CPU core; low while loading.
- `loading`  out  1  high in states LEN, DATA, DRAIN, CHECK.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERROR.

## Operation
- Stream format is a 4-byte big-endian word count N, followed by N words, each 4 bytes big-endian (MSB first).
- States:
  - LEN: collect 4 length bytes.
  - DATA: collect payload bytes.
  - DRAIN: one cycle after the final write.
  - CHECK: only with the configuration macro defined.
  - RUN: image loaded, CPU released.
  - ERROR: load failed, CPU held in reset.
- A 2-bit byte counter counts the bytes within a word. A word-index counter is ADDR_WIDTH+1 bits wide.
- LEN:
  - On the 4th byte, with N == 0: go to DRAIN (no writes).
  - N > 2^ADDR_WIDTH: go to ERROR. Compare in full 32 bits; no truncation.
  - Otherwise: go to DATA with word index = 0.
- DATA:
  - Shift bytes into a 32-bit assembly register.
  - On the 4th byte of word k, the same edge registers `imem_we`=1, `imem_addr`=k and `imem_wdata`=assembled word.
  - Word index increments on that edge.
  - If k == N-1, go to DRAIN.
- DRAIN: go to RUN unconditionally, or to CHECK when the macro is defined.
- RUN and ERROR are terminal until reset. `rx_valid` is ignored in both.
- Reset at any time, including mid-word:
  - Return to LEN and discard the partial word, the length and the counters.
  - Drive `cpu_xreset` low.
  - Memory contents already written are not cleared.
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_xreset`=0, `loading`=1, `done`=0, `error`=0.

## Timing
- Byte acceptance has no backpressure: every `rx_valid` cycle is consumed. Gaps between bytes of any length are allowed.
- Write latency: `imem_we` is high for exactly the one cycle after the edge that samples the word's last byte. It is never high two consecutive cycles.
- `cpu_xreset` rises on the edge after DRAIN, i.e. 2 cycles after the final byte's edge. This is after the final `imem_we` cycle has completed.
- With N == 0, `cpu_xreset` rises 2 cycles after the 4th length byte.
- `done`, `error` and `loading` are registered state decodes; they change on the same edge as the state.
- `cpu_xreset` is registered and glitch-free, and stays high in RUN until `xreset` falls.

## Configuration
- `LOADER_CHECKSUM_EN`, when defined:
  - A running XOR of all payload bytes (not the length bytes) is kept, reset to 0x00 on entering DATA.
  - After DRAIN, the block waits in CHECK for one more byte.
  - If that byte equals the running XOR, go to RUN (`cpu_xreset` high next edge). Otherwise go to ERROR and keep `cpu_xreset` low.
  - With N == 0, the expected checksum is 0x00.
- `LOADER_CHECKSUM_EN` not defined: no checksum register, no CHECK state; DRAIN goes directly to RUN.

## Test plan
- N=2, words 0x20020005, 0x2003000C, bytes back-to-back -> writes addr0=0x20020005, addr1=0x2003000C, one cycle each; `cpu_xreset`=1 and `done`=1 exactly 2 cycles after the last byte.
- Same stream with 50 idle cycles between each byte -> identical writes and values; release 2 cycles after the last byte.
- N=0 -> no `imem_we`; `cpu_xreset` high 2 cycles after the 4th length byte.
- N=2^ADDR_WIDTH+1 (1025 with default) -> `error`=1 after the 4th length byte; no writes; `cpu_xreset` stays 0 for 1000 further bytes.
- Reset pulse after 6 bytes of an N=2 stream, then a fresh N=1 stream of 0xDEADBEEF -> single write addr0=0xDEADBEEF, release follows.
- `LOADER_CHECKSUM_EN`, N=1 of 0x01020304:
  - Checksum byte 0x04 -> `done`=1.
  - Checksum byte 0x05 -> `error`=1 and `cpu_xreset`=0.
